// File: rtl/paddle_cmd_gen.sv
// Player button front end: two raw push-buttons become clean, mutually exclusive
// UP/DOWN move pulses with hold-to-repeat. Pipeline: sync -> debounce -> arbitrate -> repeat FSM.
module paddle_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYC  = 750000,
    parameter int unsigned REPEAT_DELAY  = 22500000,
    parameter int unsigned REPEAT_PERIOD = 3750000,
    parameter int unsigned PULSE_W       = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_UP,
    input  logic BTN_DOWN,
    output logic UP,
    output logic DOWN,
    output logic HELD
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned GAP_W = $clog2(2 * PULSE_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_DELAY,
        S_REPEAT
    } state_t;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]           btn_raw;
    logic [1:0][1:0]      sync_q, sync_d;
    logic [1:0]           db_q, db_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

    state_t               state_q, state_d;
    logic                 dir_dn_q, dir_dn_d;
    logic [RPT_W-1:0]     rpt_cnt_q, rpt_cnt_d;
    logic                 held_q, held_d;

    logic                 pend_q, pend_d;
    logic                 pend_dn_q, pend_dn_d;
    logic                 pulse_dn_q, pulse_dn_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 up_q, up_d;
    logic                 down_q, down_d;

    logic                 req_up, req_dn, dir_req;
    logic                 start, start_dn, fire, active;

    assign btn_raw = {BTN_DOWN, BTN_UP};

    always_comb begin
        sync_d   = sync_q;
        db_d     = db_q;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][0], btn_raw[i]};
            if (sync_q[i][1] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign req_up  = db_q[0] & ~db_q[1];
    assign req_dn  = db_q[1] & ~db_q[0];
    assign dir_req = dir_dn_q ? req_dn : req_up;

    // The first pulse and the repeat countdown are launched on the IDLE exit edge,
    // so the pulse appears one cycle after the request and FIRST only hands over to DELAY.
    always_comb begin
        state_d   = state_q;
        dir_dn_d  = dir_dn_q;
        rpt_cnt_d = rpt_cnt_q;
        start     = 1'b0;
        start_dn  = dir_dn_q;
        case (state_q)
            S_IDLE: begin
                if (req_up || req_dn) begin
                    dir_dn_d  = req_dn;
                    start     = 1'b1;
                    start_dn  = req_dn;
                    rpt_cnt_d = RPT_W'(REPEAT_DELAY);
                    state_d   = S_FIRST;
                end
            end
            default: begin
                if (!dir_req) begin
                    state_d = S_IDLE;
                end else if (rpt_cnt_q == RPT_W'(1)) begin
                    start     = 1'b1;
                    rpt_cnt_d = RPT_W'(REPEAT_PERIOD);
                    state_d   = S_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                    if (state_q == S_FIRST) begin
                        state_d = S_DELAY;
                    end
                end
            end
        endcase
        held_d = (state_d == S_DELAY) || (state_d == S_REPEAT);
    end

    // gap_cnt spans pulse plus mandatory low time; a start is only allowed once it
    // reaches zero, otherwise the most recent start request waits in the pending slot.
    always_comb begin
        gap_cnt_d  = (gap_cnt_q == '0) ? '0 : gap_cnt_q - GAP_W'(1);
        pend_d     = pend_q;
        pend_dn_d  = pend_dn_q;
        pulse_dn_d = pulse_dn_q;
        fire       = 1'b0;
        if (start) begin
            if (gap_cnt_q == '0) begin
                fire       = 1'b1;
                pulse_dn_d = start_dn;
                pend_d     = 1'b0;
            end else begin
                pend_d    = 1'b1;
                pend_dn_d = start_dn;
            end
        end else if (pend_q && (gap_cnt_q == '0)) begin
            fire       = 1'b1;
            pulse_dn_d = pend_dn_q;
            pend_d     = 1'b0;
        end
        if (fire) begin
            gap_cnt_d = GAP_W'(2 * PULSE_W - 1);
        end
        active = (gap_cnt_d >= GAP_W'(PULSE_W));
        up_d   = active & ~pulse_dn_d;
        down_d = active & pulse_dn_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q     <= '0;
            db_q       <= '0;
            db_cnt_q   <= '0;
            state_q    <= S_IDLE;
            dir_dn_q   <= 1'b0;
            rpt_cnt_q  <= '0;
            held_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_dn_q  <= 1'b0;
            pulse_dn_q <= 1'b0;
            gap_cnt_q  <= '0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            dir_dn_q   <= dir_dn_d;
            rpt_cnt_q  <= rpt_cnt_d;
            held_q     <= held_d;
            pend_q     <= pend_d;
            pend_dn_q  <= pend_dn_d;
            pulse_dn_q <= pulse_dn_d;
            gap_cnt_q  <= gap_cnt_d;
            up_q       <= up_d;
            down_q     <= down_d;
        end
    end

    assign UP   = up_q;
    assign DOWN = down_q;
    assign HELD = held_q;

endmodule

// File: tb/tb_paddle_cmd_gen.sv
// Scoreboard bench for paddle_cmd_gen: a behavioural model queues expected pulse
// starts; a negedge monitor matches DUT pulses, widths, exclusivity and HELD.
module tb_paddle_cmd_gen;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic up, down, held;

    always #5 clk = ~clk;

    paddle_cmd_gen #(
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .PULSE_W      (PW)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .BTN_UP  (btn_up),
        .BTN_DOWN(btn_down),
        .UP      (up),
        .DOWN    (down),
        .HELD    (held)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int t;
        bit dn;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
        end
    endtask

    // Behavioural model: timing expressed as absolute cycle numbers.
    bit m_s1[2], m_s2[2], m_db[2];
    int m_run[2];
    bit m_act, m_dn, m_pend, m_pend_dn;
    int m_next, m_last;
    bit exp_held;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
            end
            m_act = 0; m_dn = 0; m_pend = 0; m_pend_dn = 0;
            m_next = 0; m_last = -1000; exp_held = 0;
            exp_q.delete();
        end else begin
            bit ru, rd, start, sdn, allowed, raw[2];
            cyc++;
            ru = m_db[0] && !m_db[1];
            rd = m_db[1] && !m_db[0];
            start = 0; sdn = 0;
            if (m_act) begin
                if (!(m_dn ? rd : ru)) begin
                    m_act = 0; exp_held = 0;
                end else begin
                    if (cyc == m_next) begin
                        start = 1; sdn = m_dn; m_next = m_next + RP;
                    end
                    exp_held = 1;
                end
            end else if (ru || rd) begin
                m_act = 1; m_dn = rd; m_next = cyc + RD;
                start = 1; sdn = rd; exp_held = 0;
            end
            allowed = (cyc >= m_last + 2 * PW);
            if (start && allowed) begin
                m_last = cyc; m_pend = 0;
                exp_q.push_back('{t: cyc, dn: sdn});
            end else if (start) begin
                m_pend = 1; m_pend_dn = sdn;
            end else if (m_pend && allowed) begin
                m_last = cyc; m_pend = 0;
                exp_q.push_back('{t: cyc, dn: m_pend_dn});
            end
            raw[0] = btn_up; raw[1] = btn_down;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_db[i] = !m_db[i]; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    end

    // Monitor
    bit p_cur = 0, p_dn = 0;
    int run = 0;
    always @(negedge clk) begin
        if (rst) begin
            p_cur = 0; p_dn = 0; run = 0;
        end else begin
            bit cur;
            cur = up || down;
            chk("held", held, exp_held);
            chk("exclusive", up && down, 0);
            if (cur && (!p_cur || p_dn != down)) begin
                if (p_cur) chk("pulse_width", run, PW);
                if (exp_q.size() == 0) begin
                    chk("pulse_unexpected", exp_q.size(), 1);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("pulse_start", cyc, e.t);
                    chk("pulse_dir", down, e.dn);
                end
                run = 1;
            end else if (cur) begin
                run++;
            end else if (p_cur) begin
                chk("pulse_width", run, PW);
                run = 0;
            end
            if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
                chk("pulse_missing", cyc, exp_q[0].t);
                void'(exp_q.pop_front());
            end
            p_cur = cur; p_dn = down;
        end
    end

    task automatic check_restart(input int base);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (up) seen = 1;
        end
        if (!seen) begin
            chk("restart_latency", -1, 7);
        end else begin
            chk("restart_latency", cyc - base, 7);
            @(negedge clk);
            chk("restart_up_hi", up, 1);
            @(negedge clk);
            chk("restart_up_lo", up, 0);
        end
    endtask

    task automatic wait_up_rises(input int n, input int budget);
        int cnt;
        bit prev;
        cnt = 0; prev = up;
        for (int i = 0; i < budget && cnt < n; i++) begin
            @(negedge clk);
            if (up && !prev) cnt++;
            prev = up;
        end
        chk("wait_up_rises", cnt, n);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; btn_up = 1'b1; btn_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_up", up, 0);
        chk("rst_down", down, 0);
        chk("rst_held", held, 0);
        rst = 1'b0;
        base = cyc;
        check_restart(base);
        repeat (45) @(negedge clk);
        btn_up = 1'b0;
        repeat (30) @(negedge clk);

        btn_down = 1'b1; repeat (3) @(negedge clk); btn_down = 1'b0;
        repeat (30) @(negedge clk);
        btn_down = 1'b1; repeat (6) @(negedge clk); btn_down = 1'b0;
        repeat (30) @(negedge clk);

        btn_up = 1'b1; repeat (40) @(negedge clk);
        btn_down = 1'b1; repeat (40) @(negedge clk);
        chk("both_held", held, 0);
        btn_up = 1'b0; repeat (60) @(negedge clk);
        btn_down = 1'b0; repeat (30) @(negedge clk);

        btn_up = 1'b1;
        wait_up_rises(1, 60);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (40) @(negedge clk);

        btn_up = 1'b1;
        wait_up_rises(2, 100);
        #2 rst = 1'b1;
        #1 chk("rst_mid_pulse_up", up, 0);
        chk("rst_mid_pulse_held", held, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        base = cyc;
        check_restart(base);
        btn_up = 1'b0;
        repeat (30) @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0) pulse_reset();
            else if (r < 20) btn_up = ~btn_up;
            else btn_down = ~btn_down;
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        btn_up = 1'b0; btn_down = 1'b0;
        repeat (60) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
